// File: rtl/thor2022_page_walker_pkg.sv
// Shared types for the Thor2022 hardware page-table walker.
//   L1PTE / LeafPTE : layouts of the two page-table levels as read from memory
//   TLBE            : entry written into the TLB update port
//   fault_cause_e   : cause code reported with a walker fault
//   ST_*            : walker state encoding
//   TLBADR_RANDOM   : tlbadr[15:14] code asking the TLB to pick a random way
package thor2022_page_walker_pkg;

   localparam logic [1:0] TLBADR_RANDOM = 2'b10;

   typedef enum logic [1:0] {
      FC_L1_INVALID = 2'd0,
      FC_L2_INVALID = 2'd1,
      FC_BUS_ERR    = 2'd2,
      FC_TIMEOUT    = 2'd3
   } fault_cause_e;

   typedef logic [2:0] walk_state_t;
   localparam walk_state_t ST_IDLE    = 3'd0;
   localparam walk_state_t ST_L1_REQ  = 3'd1;
   localparam walk_state_t ST_L1_WAIT = 3'd2;
   localparam walk_state_t ST_L2_REQ  = 3'd3;
   localparam walk_state_t ST_L2_WAIT = 3'd4;
   localparam walk_state_t ST_TLB_WR  = 3'd5;
   localparam walk_state_t ST_FAULT   = 3'd6;
   localparam walk_state_t ST_SETTLE  = 3'd7;

   typedef struct packed {
      logic [12:0] rsvd_hi;
      logic [18:0] l2_base;   // L2 table base [31:13]
      logic [30:0] rsvd_lo;
      logic        v;
   } L1PTE;

   typedef struct packed {
      logic [11:0] key;
      logic [19:0] ppn;
      logic [11:0] rsvd_hi;
      logic [3:0]  bc;
      logic [1:0]  rsvd_lo;
      logic sx, sw, sr, sc, x, w, r, c, s, u, a, d, g, v;
   } LeafPTE;

   typedef struct packed {
      logic [7:0]  access_count;
      logic [19:0] key;
      logic [7:0]  asid;
      logic [19:0] vpn;
      logic [19:0] ppn;
      logic [3:0]  bc;
      logic sx, sw, sr, sc, x, w, r, c, s, u, a, d, g, v;
   } TLBE;

   // Leaf PTE -> TLB entry. The accessed bit is forced because the walk itself is an access.
   function automatic TLBE make_tlbe(input logic [31:0] va, input logic [7:0] asid,
                                     input LeafPTE pte);
      TLBE t;
      t      = '0;
      t.vpn  = va[31:12];
      t.asid = asid;
      t.key  = {8'h00, pte.key};
      t.ppn  = pte.ppn;
      t.bc   = pte.bc;
      {t.sx, t.sw, t.sr, t.sc, t.x, t.w, t.r, t.c, t.s, t.u, t.a, t.d, t.g, t.v} =
         {pte.sx, pte.sw, pte.sr, pte.sc, pte.x, pte.w, pte.r, pte.c, pte.s, pte.u, 1'b1,
          pte.d, pte.g, pte.v};
      return t;
   endfunction

endpackage

// File: rtl/thor2022_page_walker.sv
// Thor2022 hardware page-table walker.
// On a TLB miss it reads the L1 and leaf PTEs over a 64-bit read-only bus master, then writes
// the assembled TLBE into the TLB (random way) or reports a fault.
//   clk_i, rst_i                 : clock, async active-high reset
//   ptbr_i, asid_i               : L1 table base, current ASID
//   walk_en_i, tlbmiss_i, tlbmiss_adr_i : miss request from the TLB
//   tlb_rdy_i, wrtlb_o, tlbadr_o, tlbdat_o, done_o : TLB update port
//   cyc_o, stb_o, we_o, sel_o, adr_o, ack_i, err_i, dat_i : bus master
//   fault_o, fault_cause_o, fault_adr_o : fault report
//   busy_o                       : walk in progress
module thor2022_page_walker
   import thor2022_page_walker_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned HOLDOFF = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] ptbr_i,
   input  logic [7:0]  asid_i,
   input  logic        walk_en_i,
   input  logic        tlbmiss_i,
   input  logic [31:0] tlbmiss_adr_i,
   input  logic        tlb_rdy_i,
   output logic        busy_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [7:0]  sel_o,
   output logic [31:0] adr_o,
   input  logic        ack_i,
   input  logic        err_i,
   input  logic [63:0] dat_i,
   output logic        wrtlb_o,
   output logic [15:0] tlbadr_o,
   output TLBE         tlbdat_o,
   output logic        fault_o,
   output logic [1:0]  fault_cause_o,
   output logic [31:0] fault_adr_o,
   output logic        done_o
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned HW = $clog2(HOLDOFF + 1);

   walk_state_t  r_state, w_state_nxt;
   fault_cause_e r_cause, w_cause;
   logic [31:0]  r_va;
   logic [7:0]   r_asid;
   logic [31:0]  r_adr;
   logic [TW-1:0] r_tmo;
   logic [HW-1:0] r_hold;
   logic [15:0]  r_tlbadr;
   TLBE          r_tlbdat;
   L1PTE         w_l1;
   logic         w_wait, w_tmo_hit, w_start;
   logic         w_unused;

   assign w_l1      = dat_i;
   assign w_wait    = (r_state == ST_L1_WAIT) || (r_state == ST_L2_WAIT);
   // Fires on the last wait cycle of the budget, so the fault follows TIMEOUT silent cycles.
   assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));
   assign w_start   = (r_state == ST_IDLE) && (w_state_nxt == ST_L1_REQ);
   assign w_unused  = ^{ptbr_i[12:0], w_l1.rsvd_hi, w_l1.rsvd_lo};

   always_comb begin
      w_state_nxt = r_state;
      w_cause     = FC_BUS_ERR;
      unique case (r_state)
         ST_IDLE:    if (walk_en_i && tlbmiss_i && (r_hold == '0)) w_state_nxt = ST_L1_REQ;
         ST_L1_REQ:  w_state_nxt = ST_L1_WAIT;
         ST_L2_REQ:  w_state_nxt = ST_L2_WAIT;
         ST_L1_WAIT, ST_L2_WAIT: begin
            // err_i has priority over ack_i when both arrive together.
            if (err_i) begin
               w_state_nxt = ST_FAULT;
               w_cause     = FC_BUS_ERR;
            end else if (ack_i) begin
               if (dat_i[0]) begin
                  w_state_nxt = (r_state == ST_L1_WAIT) ? ST_L2_REQ : ST_TLB_WR;
               end else begin
                  w_state_nxt = ST_FAULT;
                  w_cause     = (r_state == ST_L1_WAIT) ? FC_L1_INVALID : FC_L2_INVALID;
               end
            end else if (w_tmo_hit) begin
               w_state_nxt = ST_FAULT;
               w_cause     = FC_TIMEOUT;
            end
         end
         ST_TLB_WR:  if (tlb_rdy_i) w_state_nxt = ST_SETTLE;
         ST_FAULT:   w_state_nxt = ST_SETTLE;
         ST_SETTLE:  w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_cause  <= FC_L1_INVALID;
         r_va     <= '0;
         r_asid   <= '0;
         r_adr    <= '0;
         r_tmo    <= '0;
         r_hold   <= '0;
         r_tlbadr <= '0;
         r_tlbdat <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (r_state == ST_SETTLE) begin
            r_hold <= HW'(HOLDOFF);
         end else if ((r_state == ST_IDLE) && (r_hold != '0)) begin
            r_hold <= r_hold - HW'(1);
         end

         // The L1 address is captured here so later ptbr_i changes cannot disturb this walk.
         if (w_start) begin
            r_va   <= tlbmiss_adr_i;
            r_asid <= asid_i;
            r_adr  <= {ptbr_i[31:13], tlbmiss_adr_i[31:22], 3'b000};
         end

         if ((r_state == ST_L1_REQ) || (r_state == ST_L2_REQ)) begin
            r_tmo <= '0;
         end else if (w_wait && (r_tmo != TW'(TIMEOUT))) begin
            r_tmo <= r_tmo + TW'(1);
         end

         if ((r_state == ST_L1_WAIT) && (w_state_nxt == ST_L2_REQ)) begin
            r_adr <= {w_l1.l2_base, r_va[21:12], 3'b000};
         end

         if ((r_state == ST_L2_WAIT) && (w_state_nxt == ST_TLB_WR)) begin
            r_tlbadr <= {TLBADR_RANDOM, 4'h0, r_va[21:12]};
            r_tlbdat <= make_tlbe(r_va, r_asid, dat_i);
         end

         if (w_state_nxt == ST_FAULT) r_cause <= w_cause;
      end
   end

   // Bus strobes decode straight from state so an async reset drops them immediately.
   assign busy_o        = (r_state != ST_IDLE);
   assign cyc_o         = (r_state == ST_L1_REQ) || (r_state == ST_L2_REQ) || w_wait;
   assign stb_o         = cyc_o;
   assign we_o          = 1'b0;
   assign sel_o         = 8'hFF;
   assign adr_o         = r_adr;
   assign wrtlb_o       = (r_state == ST_TLB_WR) && tlb_rdy_i;
   assign done_o        = wrtlb_o;
   assign tlbadr_o      = r_tlbadr;
   assign tlbdat_o      = r_tlbdat;
   assign fault_o       = (r_state == ST_FAULT);
   assign fault_cause_o = r_cause;
   assign fault_adr_o   = r_va;

endmodule

// File: tb/tb_thor2022_page_walker.sv
module tb_thor2022_page_walker;
   import thor2022_page_walker_pkg::*;

   localparam int unsigned TIMEOUT = 255;
   localparam int unsigned HOLDOFF = 8;

   logic        clk, rst_i;
   logic [31:0] ptbr_i;
   logic [7:0]  asid_i;
   logic        walk_en_i, tlbmiss_i, tlb_rdy_i;
   logic [31:0] tlbmiss_adr_i;
   logic        busy_o, cyc_o, stb_o, we_o;
   logic [7:0]  sel_o;
   logic [31:0] adr_o;
   logic        ack_i, err_i;
   logic [63:0] dat_i;
   logic        wrtlb_o, fault_o, done_o;
   logic [15:0] tlbadr_o;
   TLBE         tlbdat_o;
   logic [1:0]  fault_cause_o;
   logic [31:0] fault_adr_o;

   thor2022_page_walker #(.TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)) dut (
      .clk_i(clk), .rst_i(rst_i), .ptbr_i(ptbr_i), .asid_i(asid_i), .walk_en_i(walk_en_i),
      .tlbmiss_i(tlbmiss_i), .tlbmiss_adr_i(tlbmiss_adr_i), .tlb_rdy_i(tlb_rdy_i),
      .busy_o(busy_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
      .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i), .wrtlb_o(wrtlb_o), .tlbadr_o(tlbadr_o),
      .tlbdat_o(tlbdat_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o),
      .fault_adr_o(fault_adr_o), .done_o(done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Memory and bus slave: answers a request on the second cycle it sees cyc_o (zero-wait).
   logic [63:0] mem [logic [31:0]];
   logic [31:0] rd_log [$];
   int   s_reads = 0;
   int   err_at = 0;        // absolute read number answered with err_i (0 = none)
   bit   err_with_ack = 0;
   bit   no_resp = 0;
   logic s_cyc_after = 1'b0; // cyc_o one cycle after the last response

   initial begin : slave
      int  cnt;
      bit  resp;
      cnt = 0; resp = 0;
      ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
      forever begin
         @(negedge clk);
         if (resp) begin
            resp = 0; ack_i = 1'b0; err_i = 1'b0;
            s_cyc_after = cyc_o;
            cnt = cyc_o ? 1 : 0;
         end else if (cyc_o && stb_o) begin
            cnt++;
            if (!no_resp && cnt >= 2) begin
               s_reads++;
               rd_log.push_back(adr_o);
               resp = 1;
               if (s_reads == err_at) begin
                  err_i = 1'b1; ack_i = err_with_ack;
               end else begin
                  ack_i = 1'b1;
                  dat_i = mem.exists(adr_o) ? mem[adr_o] : 64'h0;
               end
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Walk knobs and results.
   int k_drop_at, k_ptbr_at, k_rdy_delay, k_err_rel;
   int w_finished, w_wr_cnt, w_fault_cnt, w_wr_lat, w_cyc_cycles, w_rd_base, w_reads;
   logic        w_done;
   logic [1:0]  w_cause;
   logic [31:0] w_fadr;
   logic [15:0] w_tlbadr;
   TLBE         w_tlbe;

   task automatic run_walk(input logic [31:0] va, input logic [7:0] asid);
      int cnt;
      bit seen_busy;
      repeat (HOLDOFF + 2) @(negedge clk);
      w_rd_base = s_reads;
      err_at = (k_err_rel != 0) ? s_reads + k_err_rel : 0;
      w_wr_cnt = 0; w_fault_cnt = 0; w_wr_lat = 0; w_cyc_cycles = 0; w_done = 1'b0;
      w_cause = '0; w_fadr = '0; w_tlbadr = '0; w_tlbe = '0;
      tlbmiss_adr_i = va; asid_i = asid; walk_en_i = 1'b1; tlbmiss_i = 1'b1;
      tlb_rdy_i = (k_rdy_delay == 0);
      cnt = 1; seen_busy = 0;
      while (cnt < 2000) begin
         @(negedge clk);
         cnt++;
         if (cnt == k_drop_at) begin tlbmiss_i = 1'b0; walk_en_i = 1'b0; end
         if (cnt == k_ptbr_at) ptbr_i = $urandom;
         if (k_rdy_delay != 0 && cnt == 6 + k_rdy_delay) tlb_rdy_i = 1'b1;
         #1;
         if (busy_o) seen_busy = 1;
         if (cyc_o) w_cyc_cycles++;
         if (wrtlb_o) begin
            w_wr_cnt++;
            if (w_wr_cnt == 1) begin
               w_wr_lat = cnt; w_tlbadr = tlbadr_o; w_tlbe = tlbdat_o; w_done = done_o;
            end
            tlbmiss_i = 1'b0;
         end
         if (fault_o) begin
            w_fault_cnt++; w_cause = fault_cause_o; w_fadr = fault_adr_o; tlbmiss_i = 1'b0;
         end
         if (seen_busy && !busy_o) break;
      end
      w_finished = (seen_busy && !busy_o) ? 1 : 0;
      w_reads = s_reads - w_rd_base;
      tlbmiss_i = 1'b0; walk_en_i = 1'b1; tlb_rdy_i = 1'b1;
      k_drop_at = 0; k_ptbr_at = 0; k_rdy_delay = 0; k_err_rel = 0;
   endtask

   // Directed page tables: ptbr 0x10000, va 0x00403000 -> L1 @0x10008 -> L2 @0x20018.
   localparam logic [63:0] L1_GOOD   = (64'h10 << 32) | 64'h1;
   localparam logic [63:0] LEAF_GOOD = (64'hABCDE << 32) | 64'h381;

   task automatic load_directed();
      mem.delete();
      ptbr_i = 32'h0001_0000;
      mem[32'h0001_0008] = L1_GOOD;
      mem[32'h0002_0018] = LEAF_GOOD;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({cyc_o, stb_o, we_o, sel_o, adr_o} !== {3'b000, 8'hFF, 32'h0}) begin
         errors++;
         $display("FAIL reset_bus: got %h want %h", {cyc_o, stb_o, we_o, sel_o, adr_o},
                  {3'b000, 8'hFF, 32'h0});
      end
      checks++;
      if ({wrtlb_o, done_o, tlbadr_o, tlbdat_o} !== '0) begin
         errors++;
         $display("FAIL reset_tlb: got %h want 0", {wrtlb_o, done_o, tlbadr_o, tlbdat_o});
      end
      checks++;
      if ({fault_o, fault_cause_o, fault_adr_o, busy_o} !== '0) begin
         errors++;
         $display("FAIL reset_fault: got %h want 0", {fault_o, fault_cause_o, fault_adr_o, busy_o});
      end
      rst_i = 1'b0;
   endtask

   task automatic test_basic_walk();
      load_directed();
      run_walk(32'h0040_3000, 8'h5A);
      checks++;
      if (w_finished != 1) begin errors++; $display("FAIL basic_finish: walk did not end"); end
      checks++;
      if (w_wr_lat != 6) begin errors++; $display("FAIL basic_latency: got %0d want 6", w_wr_lat); end
      checks++;
      if (w_wr_cnt != 1 || w_fault_cnt != 0) begin
         errors++; $display("FAIL basic_counts: wr=%0d fault=%0d want 1/0", w_wr_cnt, w_fault_cnt);
      end
      checks++;
      if (w_tlbadr !== 16'h8003) begin
         errors++; $display("FAIL basic_tlbadr: got %h want 8003", w_tlbadr);
      end
      checks++;
      if (w_tlbe.ppn !== 20'hABCDE || w_tlbe.vpn !== 20'h00403 || w_tlbe.a !== 1'b1 ||
          w_tlbe.asid !== 8'h5A || w_done !== 1'b1) begin
         errors++;
         $display("FAIL basic_tlbe: ppn=%h vpn=%h a=%b asid=%h done=%b want abcde/00403/1/5a/1",
                  w_tlbe.ppn, w_tlbe.vpn, w_tlbe.a, w_tlbe.asid, w_done);
      end
      checks++;
      if (w_reads != 2 || rd_log[w_rd_base] !== 32'h0001_0008 ||
          rd_log[w_rd_base + 1] !== 32'h0002_0018) begin
         errors++; $display("FAIL basic_reads: %0d reads, want 2 at 00010008/00020018", w_reads);
      end
   endtask

   task automatic test_l1_invalid();
      load_directed();
      mem[32'h0001_0008] = 64'h0;
      run_walk(32'h0040_3000, 8'h01);
      checks++;
      if (w_fault_cnt != 1 || w_cause !== 2'd0 || w_fadr !== 32'h0040_3000) begin
         errors++;
         $display("FAIL l1_invalid: faults=%0d cause=%0d adr=%h want 1/0/00403000",
                  w_fault_cnt, w_cause, w_fadr);
      end
      checks++;
      if (w_wr_cnt != 0 || w_reads != 1) begin
         errors++; $display("FAIL l1_invalid_side: wr=%0d reads=%0d want 0/1", w_wr_cnt, w_reads);
      end
   endtask

   task automatic test_bus_err();
      for (int both = 0; both < 2; both++) begin
         load_directed();
         err_with_ack = (both != 0);
         k_err_rel = 2;
         run_walk(32'h0040_3000, 8'h02);
         checks++;
         if (w_fault_cnt != 1 || w_cause !== 2'd2 || w_wr_cnt != 0) begin
            errors++;
            $display("FAIL bus_err%0d: faults=%0d cause=%0d wr=%0d want 1/2/0",
                     both, w_fault_cnt, w_cause, w_wr_cnt);
         end
         checks++;
         if (s_cyc_after !== 1'b0) begin
            errors++; $display("FAIL bus_err%0d_cyc: cyc after err=%b want 0", both, s_cyc_after);
         end
      end
      err_with_ack = 0;
   endtask

   task automatic test_timeout();
      load_directed();
      no_resp = 1;
      run_walk(32'h0040_3000, 8'h03);
      no_resp = 0;
      checks++;
      if (w_fault_cnt != 1 || w_cause !== 2'd3) begin
         errors++; $display("FAIL timeout_cause: faults=%0d cause=%0d want 1/3", w_fault_cnt, w_cause);
      end
      // One request cycle plus TIMEOUT silent wait cycles.
      checks++;
      if (w_cyc_cycles != TIMEOUT + 1 || cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_len: cyc cycles=%0d cyc_o=%b want %0d/0",
                  w_cyc_cycles, cyc_o, TIMEOUT + 1);
      end
   endtask

   task automatic test_tlb_rdy();
      load_directed();
      k_rdy_delay = 4;
      run_walk(32'h0040_3000, 8'h04);
      checks++;
      if (w_wr_lat != 10 || w_wr_cnt != 1) begin
         errors++; $display("FAIL tlb_rdy: lat=%0d wr=%0d want 10/1", w_wr_lat, w_wr_cnt);
      end
   endtask

   task automatic test_holdoff();
      int n, idle;
      bit got_done, got_cyc;
      load_directed();
      repeat (HOLDOFF + 2) @(negedge clk);
      tlbmiss_adr_i = 32'h0040_3000; asid_i = 8'h07; walk_en_i = 1'b1; tlb_rdy_i = 1'b1;
      tlbmiss_i = 1'b1;
      got_done = 0; got_cyc = 0; idle = 0;
      for (n = 0; n < 100 && !got_done; n++) begin
         @(negedge clk); #1;
         if (done_o) got_done = 1;
      end
      for (n = 0; n < 100 && !got_cyc; n++) begin
         @(negedge clk); #1;
         if (cyc_o) got_cyc = 1;
         else if (!busy_o) idle++;
      end
      tlbmiss_i = 1'b0;
      checks++;
      if (!got_done || !got_cyc) begin
         errors++; $display("FAIL holdoff_walks: done=%0d restart=%0d want 1/1", got_done, got_cyc);
      end
      // HOLDOFF ignored idle cycles, then one idle cycle that samples the miss.
      checks++;
      if (idle != HOLDOFF + 1) begin
         errors++; $display("FAIL holdoff_gap: idle=%0d want %0d", idle, HOLDOFF + 1);
      end
      for (n = 0; n < 100 && busy_o; n++) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      load_directed();
      no_resp = 1;
      repeat (HOLDOFF + 2) @(negedge clk);
      tlbmiss_adr_i = 32'h0040_3000; walk_en_i = 1'b1; tlbmiss_i = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (cyc_o !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: cyc=%b want 1", cyc_o); end
      #1 rst_i = 1'b1;
      #1;
      checks++;
      if ({cyc_o, stb_o, busy_o} !== 3'b000) begin
         errors++; $display("FAIL rst_mid: cyc/stb/busy=%b want 000", {cyc_o, stb_o, busy_o});
      end
      tlbmiss_i = 1'b0; no_resp = 0;
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   task automatic test_disabled();
      int act;
      load_directed();
      repeat (HOLDOFF + 2) @(negedge clk);
      tlbmiss_adr_i = 32'h0040_3000; walk_en_i = 1'b0; tlbmiss_i = 1'b1;
      act = 0;
      repeat (30) begin
         @(negedge clk); #1;
         if (cyc_o || busy_o) act++;
      end
      tlbmiss_i = 1'b0; walk_en_i = 1'b1;
      checks++;
      if (act != 0) begin errors++; $display("FAIL disabled: %0d active cycles want 0", act); end
   endtask

   task automatic test_random();
      logic [31:0] ptbr, va, l1adr, l2adr;
      logic [18:0] base;
      logic [63:0] l1, leaf;
      logic [7:0]  asid;
      logic [15:0] exp_adr;
      bit   l1v, leafv, exp_fault;
      int   errno, exp_cause, exp_reads, r;
      TLBE  exp_tlbe;
      for (int it = 0; it < 24; it++) begin
         ptbr = $urandom; va = $urandom; asid = 8'($urandom);
         mem.delete();
         l1adr = (ptbr & 32'hFFFF_E000) + ((va >> 22) << 3);
         base  = 19'($urandom);
         if (base == 19'(ptbr >> 13)) base = base ^ 19'h1;
         l1v   = ($urandom_range(0, 5) != 0);
         leafv = ($urandom_range(0, 5) != 0);
         l1    = ({$urandom, $urandom} & ~(64'h7FFFF << 32) & ~64'h1) | (64'(base) << 32) | 64'(l1v);
         l2adr = (32'(base) << 13) + (((va >> 12) & 32'h3FF) << 3);
         leaf  = ({$urandom, $urandom} & ~64'h1) | 64'(leafv);
         mem[l1adr] = l1;
         mem[l2adr] = leaf;
         r = $urandom_range(0, 7);
         errno = (r == 0) ? 1 : (r == 1) ? 2 : 0;
         err_with_ack = $urandom_range(0, 1);
         if (errno == 1)      begin exp_fault = 1; exp_cause = 2; exp_reads = 1; end
         else if (!l1v)       begin exp_fault = 1; exp_cause = 0; exp_reads = 1; end
         else if (errno == 2) begin exp_fault = 1; exp_cause = 2; exp_reads = 2; end
         else if (!leafv)     begin exp_fault = 1; exp_cause = 1; exp_reads = 2; end
         else                 begin exp_fault = 0; exp_cause = 0; exp_reads = 2; end
         exp_tlbe = '0;
         exp_tlbe.vpn = 20'(va >> 12);
         exp_tlbe.asid = asid;
         exp_tlbe.ppn = 20'(leaf >> 32);
         exp_tlbe.key = 20'(leaf >> 52);
         exp_tlbe.bc = 4'(leaf >> 16);
         {exp_tlbe.sx, exp_tlbe.sw, exp_tlbe.sr, exp_tlbe.sc, exp_tlbe.x, exp_tlbe.w, exp_tlbe.r,
          exp_tlbe.c, exp_tlbe.s, exp_tlbe.u, exp_tlbe.a, exp_tlbe.d, exp_tlbe.g, exp_tlbe.v} =
            14'(leaf) | 14'h8;
         exp_adr = 16'h8000 | 16'((va >> 12) & 32'h3FF);
         ptbr_i = ptbr;
         k_err_rel = errno;
         k_ptbr_at = ($urandom_range(0, 1) != 0) ? 3 : 0;
         k_drop_at = ($urandom_range(0, 1) != 0) ? 4 : 0;
         run_walk(va, asid);
         checks++;
         if (w_finished != 1 || w_fault_cnt != int'(exp_fault) || w_wr_cnt != int'(!exp_fault) ||
             w_reads != exp_reads) begin
            errors++;
            $display("FAIL rand%0d_flow: fin=%0d fault=%0d wr=%0d reads=%0d want 1/%0d/%0d/%0d",
                     it, w_finished, w_fault_cnt, w_wr_cnt, w_reads, exp_fault, !exp_fault,
                     exp_reads);
         end
         checks++;
         if (rd_log[w_rd_base] !== l1adr) begin
            errors++; $display("FAIL rand%0d_l1adr: got %h want %h", it, rd_log[w_rd_base], l1adr);
         end
         if (exp_fault) begin
            checks++;
            if (w_cause !== 2'(exp_cause) || w_fadr !== va) begin
               errors++;
               $display("FAIL rand%0d_fault: cause=%0d adr=%h want %0d/%h",
                        it, w_cause, w_fadr, exp_cause, va);
            end
         end else begin
            checks++;
            if (w_tlbe !== exp_tlbe || w_tlbadr !== exp_adr) begin
               errors++;
               $display("FAIL rand%0d_tlbe: got %h/%h want %h/%h",
                        it, w_tlbe, w_tlbadr, exp_tlbe, exp_adr);
            end
         end
      end
      err_with_ack = 0;
   endtask

   initial begin
      rst_i = 1'b1; ptbr_i = '0; asid_i = '0; walk_en_i = 1'b0; tlbmiss_i = 1'b0;
      tlbmiss_adr_i = '0; tlb_rdy_i = 1'b1;
      k_drop_at = 0; k_ptbr_at = 0; k_rdy_delay = 0; k_err_rel = 0;
      test_reset();
      test_basic_walk();
      test_l1_invalid();
      test_bus_err();
      test_timeout();
      test_tlb_rdy();
      test_holdoff();
      test_reset_mid();
      test_disabled();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
